sram_ctrl: RTL
==============

# sram_ctrl

Multi-cycle controller between the pipeline's memory stage and a 16-bit external SRAM, replacing the on-chip byte array. It converts a 32-bit word access (load or store) into two 16-bit SRAM accesses with programmable wait states. While an access is in progress it drops `ready` so the rest of the pipeline freezes. It returns the assembled 32-bit read word to the write-back path.

## Interface
Parameters:
- `WAIT_CYCLES`, default 5: cycles per 16-bit SRAM access (phase); legal range 2..15.

Ports:
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-low reset.
- `wr_en`  in  1  store request (memory-write enable from the EX/MEM register).
- `rd_en`  in  1  load request (memory-read enable).
- `addr`  in  32  ALU result, a byte address.
- `st_val`  in  32  store data (Rm value).
- `ready`  out  1  high when the pipeline may advance; low freezes all pipeline registers and the PC.
- `rd_data`  out  32  last completed load word.
- `SRAM_DQ`  inout  16  SRAM data bus.
- `SRAM_ADDR`  out  18  SRAM halfword address.
- `SRAM_WE_N`, `SRAM_OE_N`, `SRAM_CE_N`, `SRAM_UB_N`, `SRAM_LB_N`  out  1 each  active-low SRAM strobes.

## Operation
- Address mapping:
  - word = (`{addr[31:2],2'b00}` − 1024) >> 2.
  - Low half goes to `SRAM_ADDR` = {word,1'b0}[17:0]; high half goes to {word,1'b1}[17:0].
  - Higher bits are dropped, so addresses wrap.
- FSM states: IDLE, LOW, HIGH, DONE.
  - IDLE: if `wr_en` or `rd_en` is high, latch the op, address and `st_val`, then go to LOW. Write wins if both are high.
  - LOW: hold for WAIT_CYCLES cycles (phase counter), then go to HIGH.
  - HIGH: hold for WAIT_CYCLES cycles, then go to DONE.
  - DONE: one cycle, then unconditionally return to IDLE. Inputs seen in DONE are the frozen, already-served request and are ignored.
- `ready` = !((IDLE && (wr_en||rd_en)) || LOW || HIGH). This is combinational from state and inputs.
- Write phases:
  - `SRAM_DQ` drives `st_val[15:0]` in LOW and `st_val[31:16]` in HIGH.
  - `SRAM_WE_N` = 0 in every phase cycle except the last, when it is 1, so address and data are stable at the WE rising edge.
  - `SRAM_OE_N` = 1 throughout.
- Read phases:
  - `SRAM_DQ` is high-Z and `SRAM_OE_N` = 0.
  - `SRAM_DQ` is sampled on the last cycle of LOW into lo[15:0] and on the last cycle of HIGH into hi[15:0].
  - `rd_data` = {hi,lo}, updated at the DONE entry edge and held until the next load completes. Stores do not change `rd_data`.
- Outside an access:
  - `SRAM_DQ` is high-Z.
  - `SRAM_WE_N` = 1, `SRAM_OE_N` = 1, `SRAM_ADDR` = 0.
- `SRAM_CE_N`, `SRAM_UB_N` and `SRAM_LB_N` are tied to 0.

## Timing
- Reset values: state IDLE, counter 0, `rd_data` 0, `SRAM_WE_N`/`SRAM_OE_N` 1, `SRAM_ADDR` 0, `SRAM_DQ` high-Z.
  - `ready` is 1 when no request is present.
- Request seen in cycle 0:
  - `ready` is low in cycles 0..2·WAIT_CYCLES.
  - `ready` is high in cycle 2·WAIT_CYCLES+1 (DONE).
  - The pipeline advances at the end of DONE.
  - Total stall is 2·WAIT_CYCLES+1 cycles; with the default, `ready` is low for 11 cycles.
- Back-to-back accesses: the next request is accepted in the IDLE cycle immediately after DONE.
- Reset asserted mid-access:
  - Immediate return to IDLE, the bus is released, and the write is partially lost.
  - `rd_data` clears to 0.
- No requests in IDLE: the FSM stays in IDLE and the SRAM stays idle.

## Configuration
- `SRAM_CTRL_ADDR_CHECK_EN` defined: the controller ignores a request when `addr` < 1024 or word ≥ 2^17.
  - No SRAM cycle runs and `ready` stays 1.
  - An ignored load sets `rd_data` to 0 at the next edge.
- `SRAM_CTRL_ADDR_CHECK_EN` undefined: every address is mapped with wrap as described above.

## Test plan
- Reset, then hold `wr_en`=`rd_en`=0 for 20 cycles → `ready`=1 throughout, `SRAM_WE_N`=`SRAM_OE_N`=1, `rd_data`=0.
- Store 0xDEADBEEF to `addr`=1024 with WAIT_CYCLES=5 → `ready` low for 11 cycles; the SRAM model holds [0]=0xBEEF and [1]=0xDEAD; `SRAM_WE_N` is 1 in the last cycle of each phase.
- Load from `addr`=1026 after that store → same word 0; `rd_data`=0xDEADBEEF in DONE and held afterwards.
- Store 0x12345678 to `addr`=1030 then load it back → SRAM [2]=0x5678 and [3]=0x1234; `rd_data`=0x12345678; the second request starts the cycle after DONE.
- Drive `wr_en`=`rd_en`=1 together with `st_val`=0xA5A5_5A5A at `addr`=1028 → a write is performed, and `rd_data` is unchanged.
- Assert `rst`=0 in the 3rd cycle of the HIGH phase of a store → `SRAM_WE_N`=1 and `SRAM_DQ` is high-Z immediately; after release the FSM is in IDLE and `rd_data`=0.
  - With `SRAM_CTRL_ADDR_CHECK_EN` defined, a load from `addr`=512 → `ready` never drops and `rd_data`=0.

Source files
------------

// File: rtl/sram_ctrl.sv
// Word-wide load/store controller for a 16-bit async SRAM: each access runs a LOW and a HIGH
// halfword phase of WAIT_CYCLES cycles. Define SRAM_CTRL_ADDR_CHECK_EN to drop out-of-range requests.
module sram_ctrl #(
    parameter int unsigned WAIT_CYCLES = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic        rd_en,
    input  logic [31:0] addr,
    input  logic [31:0] st_val,
    output logic        ready,
    output logic [31:0] rd_data,
    inout  wire  [15:0] SRAM_DQ,
    output logic [17:0] SRAM_ADDR,
    output logic        SRAM_WE_N,
    output logic        SRAM_OE_N,
    output logic        SRAM_CE_N,
    output logic        SRAM_UB_N,
    output logic        SRAM_LB_N,
    output logic [1:0]  state_dbg
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOW  = 2'd1,
        HIGH = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t      state, state_nxt;
    logic [3:0]  cnt;
    logic        op_wr;
    logic [16:0] word;
    logic [31:0] st_q;
    logic [15:0] lo;
    logic [29:0] word_full;
    logic        req_ok;
    logic        req;
    logic        phase;
    logic        last;
    logic        dq_oe;
    logic [15:0] dq_out;
    logic        unused_bits;

    // Byte address 1024 maps to SRAM word 0; bits above the SRAM size wrap away.
    assign word_full = addr[31:2] - 30'd256;

`ifdef SRAM_CTRL_ADDR_CHECK_EN
    assign req_ok = (addr >= 32'd1024) && (word_full < 30'h20000);
`else
    assign req_ok = 1'b1;
`endif

    assign unused_bits = ^{addr[1:0], word_full[29:17]};
    assign req   = (wr_en || rd_en) && req_ok;
    assign phase = (state == LOW) || (state == HIGH);
    assign last  = (cnt == 4'(WAIT_CYCLES - 1));

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (req) state_nxt = LOW;
            LOW:  if (last) state_nxt = HIGH;
            HIGH: if (last) state_nxt = DONE;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            op_wr   <= 1'b0;
            word    <= 17'd0;
            st_q    <= 32'd0;
            lo      <= 16'd0;
            rd_data <= 32'd0;
        end else begin
            state <= state_nxt;
            cnt   <= (phase && !last) ? cnt + 4'd1 : 4'd0;
            if (state == IDLE && req) begin
                op_wr <= wr_en;
                word  <= word_full[16:0];
                st_q  <= st_val;
            end
`ifdef SRAM_CTRL_ADDR_CHECK_EN
            if (state == IDLE && rd_en && !wr_en && !req_ok)
                rd_data <= 32'd0;
`endif
            // Read data is captured at the end of each phase, when the SRAM output has settled.
            if (state == LOW && last && !op_wr)
                lo <= SRAM_DQ;
            if (state == HIGH && last && !op_wr)
                rd_data <= {SRAM_DQ, lo};
        end
    end

    always_comb begin
        SRAM_ADDR = 18'd0;
        SRAM_WE_N = 1'b1;
        SRAM_OE_N = 1'b1;
        dq_oe     = 1'b0;
        dq_out    = 16'd0;
        if (phase) begin
            SRAM_ADDR = {word, state == HIGH};
            if (op_wr) begin
                // WE rises for the final phase cycle so address/data hold across the rising edge.
                SRAM_WE_N = last;
                dq_oe     = 1'b1;
                dq_out    = (state == HIGH) ? st_q[31:16] : st_q[15:0];
            end else begin
                SRAM_OE_N = 1'b0;
            end
        end
    end

    assign SRAM_DQ   = dq_oe ? dq_out : 16'hzzzz;
    assign ready     = !((state == IDLE && req) || phase);
    assign SRAM_CE_N = 1'b0;
    assign SRAM_UB_N = 1'b0;
    assign SRAM_LB_N = 1'b0;
    assign state_dbg = state;

endmodule
